// File: rtl/cic_decim_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cic_decim_mc                                                 |
// | Description : Multi-channel CIC decimator with runtime power-of-two ratio, |
// |               gain normalisation, output saturation and a FLUSH-based      |
// |               reconfiguration sequence. Optional macro CIC_ROUND_EN adds   |
// |               round-half-up before the normalising shift.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cic_decim_mc #(
   parameter int IN_W      = 16,
   parameter int OUT_W     = 16,
   parameter int N_STAGES  = 3,
   parameter int CH        = 2,
   parameter int RMAX_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_enable,
   input  logic                  enable,
   input  logic [2:0]            decim_sel,
   input  logic [CH*IN_W-1:0]    x_in,
   input  logic                  x_valid,
   output logic                  x_ready,
   output logic [CH*OUT_W-1:0]   y_out,
   output logic                  y_valid,
   output logic [7:0]            D_active
);

   // Accumulator width covers the full CIC gain R^N at the largest ratio.
   localparam int W  = IN_W + N_STAGES * RMAX_LOG2;
   // Post-shift width must hold both the accumulator (plus rounding carry) and OUT_W.
   localparam int SW = (W + 1 > OUT_W) ? W + 1 : OUT_W;
   localparam int CW = RMAX_LOG2 + 1;

   localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic signed [SW-1:0] ONE_SW  = {{(SW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLUSH = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t          state;
   logic [2:0]      applied_code;
   logic [2:0]      log2r;
   logic [7:0]      shift;
   logic [CW-1:0]   phase;
   logic [CW-1:0]   phase_last;
   logic            accept;
   logic            tick;

   // Ratio codes beyond the built maximum saturate at RMAX_LOG2.
   function automatic logic [2:0] clamp_code(input logic [2:0] code);
      return (code > 3'(RMAX_LOG2)) ? 3'(RMAX_LOG2) : code;
   endfunction

   assign log2r      = clamp_code(applied_code);
   assign shift      = 8'(N_STAGES) * {5'd0, log2r};
   assign phase_last = (CW'(1) << log2r) - CW'(1);
   assign accept     = x_valid & x_ready & clk_enable;
   assign tick       = accept & (phase == phase_last);

   // Control FSM: IDLE -> FLUSH (clear + latch ratio) -> RUN; ratio change re-flushes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         x_ready      <= 1'b0;
         applied_code <= 3'd0;
         D_active     <= 8'd1;
      end else if (clk_enable) begin
         case (state)
            ST_IDLE: begin
               x_ready <= 1'b0;
               if (enable) state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               applied_code <= decim_sel;
               D_active     <= 8'd1 << clamp_code(decim_sel);
               state        <= ST_RUN;
               x_ready      <= 1'b1;
            end
            ST_RUN: begin
               if (!enable) begin
                  state   <= ST_IDLE;
                  x_ready <= 1'b0;
               end else if (decim_sel != applied_code) begin
                  state   <= ST_FLUSH;
                  x_ready <= 1'b0;
               end
            end
            default: begin
               state   <= ST_IDLE;
               x_ready <= 1'b0;
            end
         endcase
      end
   end

   // Shared decimation phase counter; wraps on the tick accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase <= '0;
      end else if (clk_enable) begin
         if (state == ST_FLUSH) phase <= '0;
         else if (tick)         phase <= '0;
         else if (accept)       phase <= phase + CW'(1);
      end
   end

   // Output strobe follows the tick by one cycle and freezes during stalls.
   always_ff @(posedge clk) begin
      if (rst)             y_valid <= 1'b0;
      else if (clk_enable) y_valid <= tick;
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic signed [W-1:0]     integ     [N_STAGES];
      logic signed [W-1:0]     integ_nxt [N_STAGES];
      logic signed [W-1:0]     dly       [N_STAGES];
      logic signed [W-1:0]     comb      [N_STAGES+1];
      logic signed [W-1:0]     x_ext;
      logic signed [SW-1:0]    ext;
      logic signed [SW-1:0]    biased;
      logic signed [SW-1:0]    scaled;
      logic signed [OUT_W-1:0] sat;
      logic signed [OUT_W-1:0] y_reg;

      assign x_ext = {{(W-IN_W){x_in[c*IN_W+IN_W-1]}}, x_in[c*IN_W +: IN_W]};

      // Integrator cascade, comb chain, normalising shift and saturation.
      always_comb begin
         integ_nxt[0] = integ[0] + x_ext;
         for (int k = 1; k < N_STAGES; k++) integ_nxt[k] = integ[k] + integ_nxt[k-1];
         comb[0] = integ_nxt[N_STAGES-1];
         for (int k = 0; k < N_STAGES; k++) comb[k+1] = comb[k] - dly[k];
         ext = {{(SW-W){comb[N_STAGES][W-1]}}, comb[N_STAGES]};
`ifdef CIC_ROUND_EN
         biased = (shift != 8'd0) ? ext + (ONE_SW <<< (shift - 8'd1)) : ext;
`else
         biased = ext;
`endif
         scaled = biased >>> shift;
         if (scaled > SAT_MAX)      sat = SAT_MAX[OUT_W-1:0];
         else if (scaled < SAT_MIN) sat = SAT_MIN[OUT_W-1:0];
         else                       sat = scaled[OUT_W-1:0];
      end

      // Integrators advance per accept; comb delays and output only on ticks.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int k = 0; k < N_STAGES; k++) begin
               integ[k] <= '0;
               dly[k]   <= '0;
            end
            y_reg <= '0;
         end else if (clk_enable) begin
            if (state == ST_FLUSH) begin
               for (int k = 0; k < N_STAGES; k++) begin
                  integ[k] <= '0;
                  dly[k]   <= '0;
               end
            end else if (accept) begin
               for (int k = 0; k < N_STAGES; k++) integ[k] <= integ_nxt[k];
               if (tick) begin
                  for (int k = 0; k < N_STAGES; k++) dly[k] <= comb[k];
                  y_reg <= sat;
               end
            end
         end
      end

      assign y_out[c*OUT_W +: OUT_W] = y_reg;
   end

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_mc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cic_decim_mc                                              |
// | Description : Directed self-checking bench for cic_decim_mc. Three DUTs    |
// |               (N_STAGES 3, 1 and 5) share all stimulus.                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cic_decim_mc;

`ifdef CIC_ROUND_EN
   localparam int EXP_RND = 1;
`else
   localparam int EXP_RND = 0;
`endif

   logic        clk;
   logic        rst;
   logic        clk_enable;
   logic        enable;
   logic [2:0]  decim_sel;
   logic [31:0] x_in;
   logic        x_valid;

   logic        xr_a, yv_a, xr_b, yv_b, xr_c, yv_c;
   logic [31:0] y_a, y_b, y_c;
   logic [7:0]  d_a, d_b, d_c;

   int checks = 0;
   int errors = 0;

   cic_decim_mc #(.IN_W(16), .OUT_W(16), .N_STAGES(3), .CH(2), .RMAX_LOG2(4)) u_dut_a (
      .clk(clk), .rst(rst), .clk_enable(clk_enable), .enable(enable),
      .decim_sel(decim_sel), .x_in(x_in), .x_valid(x_valid), .x_ready(xr_a),
      .y_out(y_a), .y_valid(yv_a), .D_active(d_a));

   cic_decim_mc #(.IN_W(16), .OUT_W(16), .N_STAGES(1), .CH(2), .RMAX_LOG2(4)) u_dut_b (
      .clk(clk), .rst(rst), .clk_enable(clk_enable), .enable(enable),
      .decim_sel(decim_sel), .x_in(x_in), .x_valid(x_valid), .x_ready(xr_b),
      .y_out(y_b), .y_valid(yv_b), .D_active(d_b));

   cic_decim_mc #(.IN_W(16), .OUT_W(16), .N_STAGES(5), .CH(2), .RMAX_LOG2(4)) u_dut_c (
      .clk(clk), .rst(rst), .clk_enable(clk_enable), .enable(enable),
      .decim_sel(decim_sel), .x_in(x_in), .x_valid(x_valid), .x_ready(xr_c),
      .y_out(y_c), .y_valid(yv_c), .D_active(d_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
      $fatal(1);
   end

   function automatic logic signed [15:0] lane(input logic [31:0] v, input int c);
      return v[c*16 +: 16];
   endfunction

   task automatic check_val(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      step();
      for (int i = 0; i < 20 && !xr_a; i++) step();
      check_val("ready_wait", longint'(xr_a), 1);
   endtask

   int nout;
   int nc;

   initial begin
      rst = 1'b1; clk_enable = 1'b1; enable = 1'b0; decim_sel = 3'd0;
      x_in = '0; x_valid = 1'b0;
      step(); step();
      check_val("rst_y_out",   longint'(y_a),  0);
      check_val("rst_y_valid", longint'(yv_a), 0);
      check_val("rst_x_ready", longint'(xr_a), 0);
      check_val("rst_D_active", longint'(d_a), 1);

      // R=1 identity
      rst = 1'b0; enable = 1'b1;
      wait_ready();
      check_val("r1_D_active", longint'(d_a), 1);
      for (int k = 0; k < 100; k++) begin
         x_in = {16'd0, 16'(k)}; x_valid = 1'b1;
         step();
         check_val("r1_y_valid", longint'(yv_a), 1);
         check_val("r1_y_ch0", longint'(lane(y_a, 0)), k);
      end
      x_valid = 1'b0;
      step();
      check_val("r1_y_valid_idle", longint'(yv_a), 0);

      // DC on two channels, R=4
      decim_sel = 3'd2;
      wait_ready();
      check_val("dc_D_active", longint'(d_a), 4);
      nout = 0;
      x_in = {16'(-1000), 16'(1000)};
      for (int k = 0; k < 64; k++) begin
         x_valid = 1'b1;
         step();
         if (yv_a) begin
            nout++;
            if (nout == 1) check_val("dc_first_ch0", longint'(lane(y_a, 0)), 312);
            if (nout >= 3) begin
               check_val("dc_ch0", longint'(lane(y_a, 0)), 1000);
               check_val("dc_ch1", longint'(lane(y_a, 1)), -1000);
            end
         end
      end
      x_valid = 1'b0;
      check_val("dc_pulses", nout, 16);

      // Rounding on the N_STAGES=1 instance, R=2, impulse
      decim_sel = 3'd1;
      wait_ready();
      for (int k = 0; k < 4; k++) begin
         x_in = (k == 0) ? 32'd1 : 32'd0; x_valid = 1'b1;
         step();
         if (k == 1) begin
            check_val("rnd_valid1", longint'(yv_b), 1);
            check_val("rnd_first",  longint'(lane(y_b, 0)), EXP_RND);
         end
         if (k == 3) begin
            check_val("rnd_valid2", longint'(yv_b), 1);
            check_val("rnd_second", longint'(lane(y_b, 0)), 0);
         end
      end

      // Mid-stream reconfig from R=2 to R=8
      x_in = '0; x_valid = 1'b1;
      step();
      x_valid = 1'b0; decim_sel = 3'd3;
      step();
      check_val("rcfg_ready_low", longint'(xr_a), 0);
      step();
      check_val("rcfg_ready_high", longint'(xr_a), 1);
      check_val("rcfg_D_active", longint'(d_a), 8);
      x_in = {16'(-100), 16'(100)};
      for (int k = 0; k < 8; k++) begin
         x_valid = 1'b1;
         step();
         if (k < 7) check_val("rcfg_no_early", longint'(yv_a), 0);
         else begin
            check_val("rcfg_valid", longint'(yv_a), 1);
            check_val("rcfg_ch0", longint'(lane(y_a, 0)), 23);
         end
      end

      // Stall during the y_valid pulse
      x_valid = 1'b0; clk_enable = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check_val("stall_valid", longint'(yv_a), 1);
         check_val("stall_ch0", longint'(lane(y_a, 0)), 23);
      end
      clk_enable = 1'b1;
      step();
      check_val("unstall_valid", longint'(yv_a), 0);
      check_val("unstall_hold", longint'(lane(y_a, 0)), 23);

      // Reset mid-frame, coinciding with what would be the tick accept
      for (int k = 0; k < 7; k++) begin
         x_valid = 1'b1;
         step();
         check_val("frame_no_valid", longint'(yv_a), 0);
      end
      rst = 1'b1;
      step();
      check_val("mrst_y_out",    longint'(y_a),  0);
      check_val("mrst_y_valid",  longint'(yv_a), 0);
      check_val("mrst_x_ready",  longint'(xr_a), 0);
      check_val("mrst_D_active", longint'(d_a),  1);
      rst = 1'b0; x_valid = 1'b0; enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_val("idle_x_ready", longint'(xr_a), 0);
      end

      // Full-scale negative input, R=16
      decim_sel = 3'd4; enable = 1'b1;
      wait_ready();
      check_val("fs_D_active_a", longint'(d_a), 16);
      check_val("fs_D_active_c", longint'(d_c), 16);
      nout = 0; nc = 0;
      x_in = {16'h8000, 16'h8000};
      for (int k = 0; k < 160; k++) begin
         x_valid = 1'b1;
         step();
         if (yv_c) begin
            check_val("fs_c_nonpos", longint'(lane(y_c, 0) <= 0), 1);
            if (nc >= 4) begin
               check_val("fs_c_ch0", longint'(lane(y_c, 0)), -32768);
               check_val("fs_c_ch1", longint'(lane(y_c, 1)), -32768);
            end
            nc++;
         end
         if (yv_a) begin
            if (nout >= 2) check_val("fs_a_ch0", longint'(lane(y_a, 0)), -32768);
            nout++;
         end
      end
      x_valid = 1'b0;
      check_val("fs_c_pulses", nc, 10);
      check_val("fs_a_pulses", nout, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cic_decim_mc.md
# cic_decim_mc

Parametrised multi-channel CIC decimator, successor to the single-channel fixed-order CIC/compensation front stage. It processes CH parallel lanes with a shared sample strobe. Filter order, decimation ratio and channel count are set at elaboration; the runtime ratio is selected via `decim_sel`. It sits between the upstream sample source and the compensation FIR. It adds gain normalisation, a clean reconfiguration sequence with an input-ready handshake, and optional rounding.

## Interface
Parameters:
- IN_W, 16: input sample width per channel (signed).
- OUT_W, 16: output sample width per channel (signed), OUT_W ≥ IN_W.
- N_STAGES, 3: CIC order, legal 1..5.
- CH, 2: channel count, legal 1..8.
- RMAX_LOG2, 4: log2 of maximum decimation ratio, legal 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_enable  in  1  global stall; when low, no state changes.
- enable  in  1  filter enable; low holds the filter in IDLE.
- decim_sel  in  3  ratio code; R = 2^decim_sel, clamped to 2^RMAX_LOG2.
- x_in  in  CH*IN_W  packed samples; channel c is at [c*IN_W +: IN_W].
- x_valid  in  1  sample strobe for all channels.
- x_ready  out  1  high when the block accepts input.
- y_out  out  CH*OUT_W  packed decimated samples.
- y_valid  out  1  one-cycle output strobe.
- D_active  out  8  ratio R currently applied.

## Operation
- Accept = x_valid & x_ready & clk_enable.
- Internal width per channel: W = IN_W + N_STAGES*RMAX_LOG2.
- Integrators:
  - On accept, stage 1 computes i1 += sext(x).
  - Stage k computes ik += i(k-1)_new, cascaded within the same cycle.
  - Arithmetic is two's complement, wrap-around, modulo 2^W.
- Phase counter:
  - Counts 0..R-1 on each accept.
  - The accept at count R-1 is the decimation tick; the counter wraps to 0.
- Combs:
  - On a tick, N_STAGES differentiators with delay 1 (decimated rate) run on the newest integrator output.
  - Comb delay registers update only on ticks.
- Normalisation:
  - Comb output is arithmetic-shifted right by N_STAGES*log2(R).
  - The result is saturated to OUT_W, then registered into y_out.
- R=1: integrator and comb cancel, so y equals x exactly.
- Channels are fully independent and share the counter and FSM.
- FSM states:
  - IDLE: x_ready=0. Go to FLUSH when enable=1.
  - FLUSH: clear all integrators, combs and the counter. Latch applied_code from decim_sel and update D_active. x_ready=0. After 1 cycle go to RUN.
  - RUN: x_ready=1. Go to FLUSH if decim_sel ≠ applied_code. Go to IDLE if enable=0.
- All FSM transitions occur only when clk_enable=1.
- Changing decim_sel and deasserting enable in the same cycle: go to IDLE. The new code is applied on the next FLUSH.
- An input offered while x_ready=0 is dropped. Upstream must hold it or accept the loss.

## Timing
- Reset values:
  - y_out=0, y_valid=0, x_ready=0, D_active=1.
  - State IDLE, all accumulators 0, applied_code 0.
- Latency: y_valid rises on the cycle after the tick accept. y_out is valid that same cycle.
- y_valid pulses for exactly one cycle. y_out holds its value until the next tick.
- With clk_enable low, every register holds, including y_valid. A pending strobe is therefore stretched until clk_enable returns.
- Reset asserted mid-operation wins over every other input on that edge. Any in-flight tick output is discarded.
- Reconfiguration costs 1 FLUSH cycle. The first output at the new R appears after R accepts.
- The first N_STAGES-1 outputs after a FLUSH are start-up transient from zero history. They are still flagged valid.

## Configuration
- CIC_ROUND_EN defined: before the normalising shift, add 2^(shift-1) (round half up) when shift > 0.
- CIC_ROUND_EN undefined: truncate toward -inf (plain arithmetic shift).
- Saturation is present in both builds.

## Test plan
- R=1 identity: N_STAGES=3, decim_sel=0, ramp 0..99 on ch0. Required: y equals x, 1 cycle late, one y_valid per accept.
- DC, two channels: R=4, ch0=+1000, ch1=-1000, 64 accepts.
  - Required: 16 y_valid pulses.
  - From the 3rd output onward: ch0=1000, ch1=-1000.
  - D_active=4.
- Rounding build: N_STAGES=1, R=2, ch0 impulse 1,0,0,0.
  - With CIC_ROUND_EN: first output 1.
  - Without it: first output 0.
  - Second output 0 in both builds.
- Mid-stream reconfig: in RUN at R=2, change decim_sel to 3.
  - Required: x_ready low exactly 1 cycle, D_active becomes 8, counter restarts.
  - Next y_valid comes 8 accepts later.
- Stall and reset: drop clk_enable for 5 cycles during a y_valid pulse.
  - Required: y_valid and y_out frozen for the stall.
  - Then assert rst for 1 cycle mid-frame. Required: all outputs at reset values next cycle, state IDLE.
- Full-scale saturation: R=16, N_STAGES=5, all inputs -32768 on every channel.
  - Required: no wrap artefact.
  - Steady output is exactly -32768 and never exceeds range.
